// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// state encoding, default geometry and counter width helper.
package add_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_WORDS  = 4;
    localparam int DEF_SETTLE = 1;

    // A counter over n values never collapses below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = cnt_w(DEF_WORDS);
    localparam int DEF_CNT_W = cnt_w(DEF_SETTLE);

endpackage

// File: rtl/add_seq_ctrl_add16_slice.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells;
// this is the single datapath resource time-shared by the sequencer.
module add16_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    logic carry;

    always_comb begin
        s     = '0;
        carry = ci;
        for (int i = 0; i < WIDTH; i++) begin
            {carry, s[i]} = full_add(a[i], b[i], carry);
        end
        co = carry;
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared adder slice walks the
// operand words LSB first, chaining the carry through a register.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WORDS  = DEF_WORDS,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [WORDS*WIDTH-1:0] op_a,
    input  logic [WORDS*WIDTH-1:0] op_b,
    output logic                   busy,
    output logic                   done,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int N     = WORDS * WIDTH;
    localparam int IDX_W = cnt_w(WORDS);
    localparam int CNT_W = cnt_w(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_sh_q, a_sh_d;
    logic [N-1:0]     b_sh_q, b_sh_d;
    logic [N-1:0]     res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] slice_s;
    logic             slice_co;

    add16_slice #(.WIDTH(WIDTH)) u_slice (
        .a  (a_sh_q[WIDTH-1:0]),
        .b  (b_sh_q[WIDTH-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        carry_d      = carry_q;
        word_idx_d   = word_idx_q;
        settle_cnt_d = settle_cnt_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // Subtraction is folded in at acceptance: a + ~b + ~cin.
                if (start) begin
                    a_sh_d       = op_a;
                    b_sh_d       = op_b ^ {N{sub}};
                    carry_d      = cin ^ sub;
                    word_idx_d   = '0;
                    settle_cnt_d = '0;
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                if (settle_cnt_q == LAST_CNT) begin
                    settle_cnt_d = '0;
                    res_sh_d     = {slice_s, res_sh_q[N-1:WIDTH]};
                    carry_d      = slice_co;
                    a_sh_d       = a_sh_q >> WIDTH;
                    b_sh_d       = b_sh_q >> WIDTH;
                    word_idx_d   = word_idx_q + IDX_W'(1);
                    if (word_idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                        sum_d   = {slice_s, res_sh_q[N-1:WIDTH]};
                        cout_d  = slice_co;
                        ovf_d   = (a_sh_q[WIDTH-1] == b_sh_q[WIDTH-1]) &&
                                  (slice_s[WIDTH-1] != a_sh_q[WIDTH-1]);
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            carry_q      <= 1'b0;
            word_idx_q   <= '0;
            settle_cnt_q <= '0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            carry_q      <= carry_d;
            word_idx_q   <= word_idx_d;
            settle_cnt_q <= settle_cnt_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add/subtract sequencer that time-shares one WIDTH-bit ripple-carry adder slice across WORDS operand words, least-significant word first. The carry is chained through a register between words. Each word may be given SETTLE cycles of combinational ripple time before its result is captured. It sits between a requester issuing start/operands and the shared adder datapath, and presents a registered wide result with a start/busy/done handshake.

Parameters:
WIDTH, 16, bit width of the shared adder slice
WORDS, 4, number of slice passes; operand width = WORDS*WIDTH
SETTLE, 1, cycles each word is held on the adder before capture (legal range >=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset; asynchronous, active-high
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in)
cin  input  1  carry-in / borrow-in
op_a  input  WORDS*WIDTH  operand A
op_b  input  WORDS*WIDTH  operand B
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the result registers update
sum  output  WORDS*WIDTH  registered result
cout  output  1  final carry out (sub mode: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0; all internal shift/count registers cleared. An operation in flight is abandoned and no done pulse is issued.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at a rising edge:
  - latch op_a into a_sh
  - latch op_b XOR {sub} into b_sh
  - carry <= cin XOR sub
  - latch sub into the mode register
  - word_idx=0, settle_cnt=0
  - next state CALC
- IDLE, start=0: remain in IDLE.
- CALC:
  - Slice inputs: a_sh[WIDTH-1:0], b_sh[WIDTH-1:0], carry.
  - Each cycle settle_cnt increments.
  - When settle_cnt==SETTLE-1:
    - shift slice sum into res_sh at the MSB end, shifting res_sh right by WIDTH
    - carry <= slice cout
    - shift a_sh and b_sh right by WIDTH
    - settle_cnt <= 0
    - word_idx++
  - When this capture happens with word_idx==WORDS-1, next state is FIN.
  - Also on the final capture: record ovf_int = (a_msb == b'_msb) && (slice_sum_msb != a_msb), where b' is the inverted B in sub mode.
- FIN (exactly one cycle):
  - sum <= res_sh, cout <= carry, ovf <= ovf_int, all registered on entry to FIN.
  - done=1 during this cycle only; next state IDLE.
- Latency: the done pulse occurs WORDS*SETTLE+1 cycles after the edge that sampled start. Default parameters give 5 cycles.
- sum/cout/ovf hold their values until the next FIN; they change only on the FIN update or on reset.
- start while busy=1 (CALC or FIN) is ignored, not queued. If start is held continuously, the next operation is accepted in the IDLE cycle following FIN, so throughput is one operation per WORDS*SETTLE+2 cycles.
- Operand and sub inputs are don't-care after acceptance; only the latched copies are used.
- Width rules:
  - The slice is pure WIDTH-bit arithmetic; carry is 1 bit.
  - Wrap-around modulo 2^(WORDS*WIDTH); the excess carry appears only on cout.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, FIN=2'd2)
  - the default WIDTH/WORDS/SETTLE constants
  - the counter widths, derived by clog2 of WORDS and SETTLE
- One sub-module, add16_slice: combinational WIDTH-bit ripple-carry adder (a, b, ci -> s, co) built from full-adder cells.
- The controller instantiates exactly one add16_slice, which is the shared resource.

Test Plan:
1. Reset: assert rst mid-idle -> busy=0, done=0, sum=0, cout=0, ovf=0 immediately, without waiting for a clock edge.
2. Add wrap: WORDS=4, SETTLE=1, op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0, cin=1, sub=0 -> done exactly 5 cycles after start; sum=0, cout=1, ovf=0.
3. Signed overflow: op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=1, cin=0, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
4. Subtract with borrow: op_a=0, op_b=1, cin=0, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Then op_a=5, op_b=3, sub=1, cin=1 -> sum=1, cout=1.
5. Handshake: hold start=1 for 20 cycles with changing operands -> operations accepted only in IDLE, one every 6 cycles; each done is a single cycle; mid-flight operand changes do not affect results.
6. SETTLE=3, mid-flight reset: start an add, verify done at 13 cycles; start again, assert rst on cycle 7 -> busy=0, sum=0, no done pulse; a new start afterwards completes correctly.
